// File: rtl/grid_row_clear_if.sv
// Placement handshake and grid/score status bundle for grid_row_clear.
// master = placement source / display side, slave = the row-clear engine.
interface grid_row_clear_if #(
    parameter int SCORE_W = 8
);
    logic               place_valid;
    logic [11:0]        place_mask;
    logic               place_ready;
    logic [11:0]        grid;
    logic               busy;
    logic               clear_pulse;
    logic [2:0]         cleared_row;
    logic [SCORE_W-1:0] score;
    logic               overlap_err;

    modport master (
        output place_valid, place_mask,
        input  place_ready, grid, busy, clear_pulse, cleared_row, score, overlap_err
    );

    modport slave (
        input  place_valid, place_mask,
        output place_ready, grid, busy, clear_pulse, cleared_row, score, overlap_err
    );
endinterface

// File: rtl/grid_row_clear.sv
// Row-clear engine for the 4x3 grid: accepts placements, then clears full rows top-first, one per pass.
// Define GRID_FLASH_EN to blank each full row for FLASH_CYCLES cycles before it collapses.
module grid_row_clear #(
    parameter int FLASH_CYCLES = 2,
    parameter int SCORE_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    grid_row_clear_if.slave bus,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FLASH = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        grid_q, grid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         row_q, row_d;
    logic               ovl_q, ovl_d;
    logic [2:0]         full_sel;
    logic [11:0]        collapsed;
    logic [SCORE_W-1:0] score_inc;

`ifdef GRID_FLASH_EN
    localparam int CNT_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      row_mask;
`endif

    // Handshake: a placement transfers on a rising edge where place_valid && place_ready;
    // place_ready is high only in IDLE, and place_mask matters only on that edge.
    assign bus.place_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.clear_pulse = (state_q == SHIFT);
    assign bus.cleared_row = row_q;
    assign bus.score       = score_q;
    assign bus.overlap_err = ovl_q;
    assign dbg_state       = state_q;

`ifdef GRID_FLASH_EN
    assign row_mask = {{4{row_q[2]}}, {4{row_q[1]}}, {4{row_q[0]}}};
    assign bus.grid = (state_q == FLASH) ? (grid_q & ~row_mask) : grid_q;
`else
    assign bus.grid = grid_q;
`endif

    // Top row wins so collapses proceed from the top of the stack downward.
    always_comb begin
        full_sel = 3'b000;
        if (&grid_q[3:0])       full_sel = 3'b001;
        else if (&grid_q[7:4])  full_sel = 3'b010;
        else if (&grid_q[11:8]) full_sel = 3'b100;
    end

    always_comb begin
        collapsed = grid_q;
        case (row_q)
            3'b001:  collapsed = {grid_q[11:4], 4'b0000};
            3'b010:  collapsed = {grid_q[11:8], grid_q[3:0], 4'b0000};
            3'b100:  collapsed = {grid_q[7:4], grid_q[3:0], 4'b0000};
            default: collapsed = grid_q;
        endcase
    end

    assign score_inc = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        score_d = score_q;
        row_d   = row_q;
        ovl_d   = 1'b0;
`ifdef GRID_FLASH_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.place_valid) begin
                    grid_d  = grid_q | bus.place_mask;
                    ovl_d   = |(grid_q & bus.place_mask);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                row_d = full_sel;
                if (full_sel == 3'b000) begin
                    state_d = IDLE;
                end else begin
`ifdef GRID_FLASH_EN
                    cnt_d   = CNT_LOAD;
                    state_d = FLASH;
`else
                    state_d = SHIFT;
`endif
                end
            end
            FLASH: begin
`ifdef GRID_FLASH_EN
                if (cnt_q == '0) state_d = SHIFT;
                else             cnt_d   = cnt_q - CNT_W'(1);
`else
                state_d = IDLE;
`endif
            end
            SHIFT: begin
                grid_d  = collapsed;
                score_d = score_inc;
                row_d   = 3'b000;
                state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            score_q <= '0;
            row_q   <= 3'b000;
            ovl_q   <= 1'b0;
`ifdef GRID_FLASH_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            score_q <= score_d;
            row_q   <= row_d;
            ovl_q   <= ovl_d;
`ifdef GRID_FLASH_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_grid_row_clear.sv
// Self-checking bench for grid_row_clear: directed scenarios plus random placements
// checked against a row-list model of the grid.
module tb_grid_row_clear;

    localparam int FC = 2;
    localparam int SW = 2;
`ifdef GRID_FLASH_EN
    localparam int FL = FC;
`else
    localparam int FL = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] dbg_state;

    grid_row_clear_if #(.SCORE_W(SW)) bus ();

    grid_row_clear #(.FLASH_CYCLES(FC), .SCORE_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [11:0]   m_grid = '0;
    logic [SW-1:0] m_score = '0;
    logic [2:0]    exp_q[$];
    logic [11:0]   pre_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Mid-cycle asynchronous reset; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.grid !== 12'h000) begin bad++; $display("FAIL rst_grid: got %h exp 000", bus.grid); end
        total++; if (bus.score !== '0) begin bad++; $display("FAIL rst_score: got %0d exp 0", bus.score); end
        total++; if (bus.place_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b exp 1", bus.place_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        total++; if (bus.cleared_row !== 3'b000) begin bad++; $display("FAIL rst_row: got %b exp 000", bus.cleared_row); end
        total++; if (bus.clear_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b exp 0", bus.clear_pulse); end
        total++; if (bus.overlap_err !== 1'b0) begin bad++; $display("FAIL rst_ovl: got %b exp 0", bus.overlap_err); end
        @(negedge clk);
        reset = 1'b0;
        m_grid = '0;
        m_score = '0;
    endtask

    // Driver + model + scoreboard for one placement; starts and ends on a falling edge.
    task automatic place(input logic [11:0] m);
        logic        exp_ovl;
        logic [11:0] g;
        logic [11:0] rm;
        int          r;
        int          n_clear;
        int          busy_cyc;
        int          guard;
        exp_ovl = |(m_grid & m);
        g = m_grid | m;
        n_clear = 0;
        for (int k = 0; k < 3; k++) begin
            r = -1;
            for (int i = 0; i < 3; i++) if (r < 0 && g[i*4 +: 4] == 4'hF) r = i;
            if (r >= 0) begin
                exp_q.push_back(3'(1 << r));
                pre_q.push_back(g);
                for (int i = r; i > 0; i--) g[i*4 +: 4] = g[(i-1)*4 +: 4];
                g[3:0] = 4'h0;
                if (m_score != {SW{1'b1}}) m_score = m_score + 1'b1;
                n_clear++;
            end
        end

        guard = 0;
        while (bus.place_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++; if (guard >= 50) begin bad++; $display("FAIL ready_wait: got %b exp 1", bus.place_ready); end

        bus.place_valid = 1'b1;
        bus.place_mask  = m;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.overlap_err !== exp_ovl) begin bad++; $display("FAIL overlap: got %b exp %b mask %h", bus.overlap_err, exp_ovl, m); end

        busy_cyc = 0;
        while (bus.busy === 1'b1 && busy_cyc < 40) begin
            bus.place_valid = 1'($urandom_range(0, 1));
            bus.place_mask  = 12'($urandom_range(0, 4095));
            busy_cyc++;
            if (busy_cyc > 1) begin
                total++; if (bus.overlap_err !== 1'b0) begin bad++; $display("FAIL overlap_len: got %b exp 0", bus.overlap_err); end
            end
            if (bus.clear_pulse === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL extra_clear: got row %b exp none", bus.cleared_row);
                end else begin
                    if (bus.cleared_row !== exp_q[0] || bus.grid !== pre_q[0]) begin
                        bad++; $display("FAIL shift: got row %b grid %h exp row %b grid %h", bus.cleared_row, bus.grid, exp_q[0], pre_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(pre_q.pop_front());
                end
            end else if (bus.cleared_row !== 3'b000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL flash_row: got %b exp 000", bus.cleared_row);
                end else begin
                    rm = {{4{exp_q[0][2]}}, {4{exp_q[0][1]}}, {4{exp_q[0][0]}}};
                    if (bus.cleared_row !== exp_q[0] || bus.grid !== (pre_q[0] & ~rm)) begin
                        bad++; $display("FAIL flash: got row %b grid %h exp row %b grid %h", bus.cleared_row, bus.grid, exp_q[0], pre_q[0] & ~rm);
                    end
                end
            end
            @(negedge clk);
        end
        bus.place_valid = 1'b0;

        total++; if (busy_cyc != 1 + n_clear * (FL + 2)) begin bad++; $display("FAIL busy_len: got %0d exp %0d", busy_cyc, 1 + n_clear * (FL + 2)); end
        total++; if (bus.grid !== g) begin bad++; $display("FAIL grid: got %h exp %h", bus.grid, g); end
        total++; if (bus.score !== m_score) begin bad++; $display("FAIL score: got %0d exp %0d", bus.score, m_score); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL missing_clear: got %0d left exp 0", exp_q.size()); end
        total++; if (bus.cleared_row !== 3'b000 || bus.clear_pulse !== 1'b0) begin bad++; $display("FAIL idle_out: got row %b pulse %b exp 000 0", bus.cleared_row, bus.clear_pulse); end
        exp_q.delete();
        pre_q.delete();
        m_grid = g;
    endtask

    task automatic test_reset();
        do_reset();
        place(12'h0A5);
        do_reset();
    endtask

    task automatic test_no_clear();
        do_reset();
        place(12'h001);
        place(12'h003);
        total++; if (bus.grid !== 12'h003) begin bad++; $display("FAIL no_clear_grid: got %h exp 003", bus.grid); end
    endtask

    task automatic test_bottom_clear();
        do_reset();
        place(12'h0A5);
        place(12'hF00);
        total++; if (bus.grid !== 12'hA50 || bus.score !== 2'd1) begin bad++; $display("FAIL bottom: got %h/%0d exp a50/1", bus.grid, bus.score); end
    endtask

    task automatic test_triple_clear();
        do_reset();
        place(12'h7FF);
        place(12'h800);
        total++; if (bus.grid !== 12'h000 || bus.score !== 2'd3) begin bad++; $display("FAIL triple: got %h/%0d exp 000/3", bus.grid, bus.score); end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        bus.place_valid = 1'b1;
        bus.place_mask  = 12'hF00;
        @(posedge clk);
        @(negedge clk);
        bus.place_valid = 1'b0;
`ifdef GRID_FLASH_EN
        @(posedge clk);
        #2;
`else
        #1;
`endif
        total++; if (bus.clear_pulse !== 1'b0) begin bad++; $display("FAIL mid_pre_pulse: got %b exp 0", bus.clear_pulse); end
        reset = 1'b1;
        #1;
        total++; if (bus.grid !== 12'h000 || bus.score !== '0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset: got %h/%0d/%b exp 000/0/0", bus.grid, bus.score, bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.place_ready !== 1'b1 || bus.clear_pulse !== 1'b0 || bus.grid !== 12'h000 || bus.score !== '0) begin
                bad++; $display("FAIL after_mid_reset: got rdy %b pulse %b grid %h score %0d exp 1 0 000 0", bus.place_ready, bus.clear_pulse, bus.grid, bus.score);
            end
        end
        m_grid = '0;
        m_score = '0;
    endtask

    task automatic test_saturation();
        logic [SW-1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            place(12'hF00);
            total++; if (bus.score !== seq[i]) begin bad++; $display("FAIL sat_%0d: got %0d exp %0d", i, bus.score, seq[i]); end
        end
    endtask

    task automatic test_random();
        logic [11:0] m;
        int          r;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: m = 12'($urandom_range(0, 4095)) & 12'($urandom_range(0, 4095)) & 12'($urandom_range(0, 4095));
                1: begin
                    r = $urandom_range(0, 2);
                    m = (~m_grid & (12'hF << (4 * r))) | (12'($urandom_range(0, 4095)) & 12'($urandom_range(0, 4095)));
                end
                2: m = ~m_grid;
                default: m = 12'($urandom_range(0, 4095));
            endcase
            place(m);
        end
    endtask

    initial begin
        bus.place_valid = 1'b0;
        bus.place_mask  = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_no_clear();
        test_bottom_clear();
        test_triple_clear();
        test_reset_mid_clear();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
